// File: rtl/sub_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sub_bus_rr_arbiter
//
// Purpose:
//   Shares one downstream valid/ready channel among N_REQ upstream requesters.
//   One requester is granted at a time. Priority rotates after every grant, so
//   no requester can starve. The data path is purely combinational from the
//   registered grant state. There is no storage on the payload path.
//
// Build option (macro SUB_BUS_ARB_BURST_LOCK_EN):
//   defined   - a grant is held for a burst. It ends on a beat carrying last,
//               or on the MAX_BURST-th beat, whichever comes first.
//   undefined - every grant ends after exactly one beat. There is no beat
//               counter. out_last still mirrors the granted requester.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     per-requester valid                        [N_REQ]
//   req_data      per-requester payload (packed 2D)          [N_REQ][DATA_W]
//   req_last      per-requester end-of-burst marker          [N_REQ]
//   req_ready     per-requester ready, one-hot or zero       [N_REQ]
//   out_valid     downstream valid
//   out_data      downstream payload                         [DATA_W]
//   out_last      downstream last
//   out_src       index of the granted requester            [$clog2(N_REQ)]
//   out_ready     downstream ready
//   grant_busy    high while a grant is active
// -----------------------------------------------------------------------------
module sub_bus_rr_arbiter #(
    parameter int N_REQ     = 3,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]               req_last,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic [$clog2(N_REQ)-1:0]       out_src,
    input  logic                           out_ready,
    output logic                           grant_busy
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_param_check
        $error("sub_bus_rr_arbiter: parameter out of range");
    end

    // Adds an offset to a requester index and wraps it modulo N_REQ.
    // Offsets never exceed N_REQ, so a single subtraction is enough.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_pick;
    logic             w_any_req;
    logic             w_beat;
    logic             w_release;

    assign w_beat = (r_state == ST_GRANT) & req_valid[r_gnt_idx] & out_ready;

`ifdef SUB_BUS_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;
    logic             w_burst_end;

    // When last and the burst limit land on the same beat, this still gives a single release.
    assign w_burst_end = ((r_beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));
    assign w_release   = w_beat & (req_last[r_gnt_idx] | w_burst_end);

    // Beat counter next value: cleared between grants, and it holds while stalled.
    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if ((r_state == ST_IDLE) || w_release) begin
            w_beat_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_beat) begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end else begin
            w_beat_cnt_nxt = r_beat_cnt;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= {CNT_W{1'b0}};
        end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
`else
    assign w_release = w_beat;
`endif

    // Round-robin search: the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = r_rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any_req && req_valid[wrap_add(r_rr_ptr, i)]) begin
                w_any_req = 1'b1;
                w_pick    = wrap_add(r_rr_ptr, i);
            end else begin
                w_any_req = w_any_req;
            end
        end
    end

    // FSM state register, together with the grant index and the rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= {IDX_W{1'b0}};
            r_rr_ptr  <= {IDX_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_rr_ptr  <= w_ptr_nxt;
        end
    end

    // FSM next state: arbitrate in IDLE, and release on the final beat of a grant.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = wrap_add(r_gnt_idx, 32'd1);
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: route the granted requester to the downstream channel; drive zeros in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_data  = {DATA_W{1'b0}};
        out_last  = 1'b0;
        req_ready = {N_REQ{1'b0}};
        case (r_state)
            ST_GRANT: begin
                out_valid            = req_valid[r_gnt_idx];
                out_data             = req_data[r_gnt_idx];
                out_last             = req_last[r_gnt_idx];
                req_ready[r_gnt_idx] = out_ready;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_src    = r_gnt_idx;
    assign grant_busy = (r_state == ST_GRANT);

endmodule

// File: doc/sub_bus_rr_arbiter.md
# sub_bus_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready channel among `N_REQ` upstream requesters, each supplying a `DATA_W`-bit packed payload with a `last` marker. It sits in front of a shared consumer such as a `sub1`-style sink. It grants one requester at a time, holds the grant for a burst, then rotates priority so no requester starves.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `DATA_W`, default 8: payload width.
- `MAX_BURST`, default 4: maximum beats per grant, at least 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_data`  in  `[N_REQ-1:0][DATA_W-1:0]`  per-requester payload, as a packed 2D array.
- `req_last`  in  `N_REQ`  per-requester end-of-burst marker.
- `req_ready`  out  `N_REQ`  per-requester ready; one-hot or zero.
- `out_valid`  out  1  downstream valid.
- `out_data`  out  `DATA_W`  downstream payload.
- `out_last`  out  1  downstream last.
- `out_src`  out  `$clog2(N_REQ)`  index of the granted requester.
- `out_ready`  in  1  downstream ready.
- `grant_busy`  out  1  high while in GRANT.

## Operation
- The FSM has two states, IDLE and GRANT. Registered state: `state`, `gnt_idx`, `rr_ptr`, `beat_cnt` (`$clog2(MAX_BURST+1)` bits).
- **IDLE:**
  - If any `req_valid` is set, select the first set bit searching upward from `rr_ptr`, wrapping from `N_REQ-1` to 0.
  - Register that index into `gnt_idx`, clear `beat_cnt`, and move to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- **GRANT, combinational path:**
  - `out_valid` = `req_valid[gnt_idx]`.
  - `out_data` = `req_data[gnt_idx]`.
  - `out_last` = `req_last[gnt_idx]`.
  - `req_ready[gnt_idx]` = `out_ready`; all other `req_ready` bits are 0.
- **Beats and release:**
  - A beat is `out_valid & out_ready`. Each beat increments `beat_cnt`.
  - Release occurs on a beat with `out_last=1`, or on the beat where `beat_cnt+1 == MAX_BURST`.
  - On release: go to IDLE and set `rr_ptr` = `gnt_idx+1`, wrapping to 0 after `N_REQ-1`.
- **Grant hold:** if the granted requester drops `req_valid` mid-burst, the grant is held. `out_valid` goes to 0 and no other requester is served.
- **Outputs in IDLE:** `out_valid`, `out_data`, `out_last` and `req_ready` are all 0. `out_src` and `grant_busy` reflect registered state.
- **Reset values:**
  - `state`=IDLE, `rr_ptr`=0, `gnt_idx`=0, `beat_cnt`=0.
  - All outputs are 0.
- **Reset mid-burst:** the in-flight burst is abandoned with no completion beat, and the outputs drop to 0 asynchronously.

## Timing
- Arbitration takes 1 cycle. A request seen in IDLE at edge k gives its first possible beat in cycle k+1.
- There is one IDLE bubble cycle between consecutive grants, including when the same requester wins again.
- `out_*` and `req_ready` are combinational from registered state, requester inputs and `out_ready`. There are no registers on the data path.
- **Transfer rule:** a transfer completes only on `valid & ready`. While `out_ready`=0, `out_data` tracks the granted requester and `beat_cnt` holds.
- **Simultaneous last and MAX_BURST:** a single release.
- **Simultaneous requests in IDLE:** resolved only by the `rr_ptr` order.

## Configuration
- The macro is `SUB_BUS_ARB_BURST_LOCK_EN`.
- **Defined:** grant hold and release work as described above, ending on `last` or `MAX_BURST`.
- **Undefined:**
  - Every grant ends after exactly one beat, regardless of `req_last`.
  - `beat_cnt` logic is removed.
  - `out_last` still passes through `req_last[gnt_idx]`.

## Test plan
- **Single burst:** requester 1 sends 3 beats, with `last` on beat 3 and `out_ready`=1. Required: one IDLE cycle, then 3 beats with `out_src`=1, then IDLE with `rr_ptr`=2.
- **Rotation:** all three requesters are valid continuously with `last`=0 and `MAX_BURST`=4. Required: grants 0,1,2,0, each 4 beats, with one bubble cycle between grants.
- **Backpressure:** `out_ready` is low for 2 cycles mid-burst on beat 2 (data 0xA5). Required: `out_data` stays 0xA5, `req_ready` stays 0 and `beat_cnt` stays unchanged; the burst then completes at 4 beats.
- **Valid drop:** requester 0 drops `req_valid` for 3 cycles mid-burst while requester 2 is valid. Required: `out_valid`=0 and requester 2 is not served until requester 0's `last` beat.
- **Reset mid-burst:** `rst` is asserted during a requester 2 burst. Required: outputs are 0 immediately. After release, with requesters 0 and 2 both valid, requester 0 wins.
- **Macro undefined:** requesters 0 and 2 are valid continuously. Required: single-beat grants alternating 0,2,0,2, each separated by one IDLE cycle.
